// File: rtl/multdiv_pkg.sv
// Shared definitions for the multdiv arbitration slice.
// Contents: lane count, operation codes and the arbiter FSM state encoding.
package multdiv_pkg;

    localparam int LANES = 4;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/multdiv_arbiter_rr_pick4.sv
// rr_pick4: combinational round-robin picker for four lanes.
// Ports:
//   req[3:0]  in   request vector
//   ptr[1:0]  in   lane with highest priority; the scan wraps from 3 to 0
//   gnt[3:0]  out  one-hot winner (zero when no request)
//   idx[1:0]  out  binary index of the winner (zero when no request)
//   any       out  at least one lane is requesting
module rr_pick4
    import multdiv_pkg::*;
(
    input  logic [LANES-1:0] req,
    input  logic [1:0]       ptr,
    output logic [LANES-1:0] gnt,
    output logic [1:0]       idx,
    output logic             any
);

    logic [1:0] lane;

    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        lane = '0;
        for (int i = 0; i < LANES; i++) begin
            // Two-bit addition wraps naturally from lane 3 back to lane 0.
            lane = ptr + i[1:0];
            if (!any && req[lane]) begin
                any       = 1'b1;
                gnt[lane] = 1'b1;
                idx       = lane;
            end
        end
    end

endmodule

// File: rtl/multdiv_arbiter.sv
// multdiv_arbiter: shares one multdiv unit among four requester lanes.
// Round-robin arbitrates, drives the operand mux select, issues a one-cycle
// multiply/divide start pulse, waits for completion and returns the
// registered result to the granted lane.
//
// Ports:
//   clock, reset           rising-edge clock, synchronous active-high reset
//   req[3:0], req_op[3:0]  per-lane request level and operation (0 mul, 1 div)
//   grant[3:0]             one-hot grant, held from ISSUE through RESP
//   mux_sel[1:0]           granted lane index for both operand muxes
//   ctrl_MULT, ctrl_DIV    one-cycle start pulses to the multdiv core
//   data_resultRDY         multdiv completion
//   data_exception         multdiv exception flag
//   data_result[31:0]      multdiv result
//   resp_valid[3:0]        one-hot, one-cycle response strobe
//   resp_result[31:0]      registered result, valid with resp_valid
//   resp_exception         registered exception, valid with resp_valid
//
// Build option: define MULTDIV_ARB_TIMEOUT_EN to abandon a WAIT after
// TIMEOUT_CYCLES cycles and answer with result 0 and exception 1.
// All outputs come straight from flops.
module multdiv_arbiter
    import multdiv_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 40
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [LANES-1:0]  req,
    input  logic [LANES-1:0]  req_op,
    output logic [LANES-1:0]  grant,
    output logic [1:0]        mux_sel,
    output logic              ctrl_MULT,
    output logic              ctrl_DIV,
    input  logic              data_resultRDY,
    input  logic              data_exception,
    input  logic [31:0]       data_result,
    output logic [LANES-1:0]  resp_valid,
    output logic [31:0]       resp_result,
    output logic              resp_exception
);

    arb_state_t       state_q, state_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [LANES-1:0] grant_q, grant_d;
    logic [1:0]       mux_sel_q, mux_sel_d;
    logic             op_q, op_d;
    logic             mult_q, mult_d;
    logic             div_q, div_d;
    logic [LANES-1:0] resp_valid_q, resp_valid_d;
    logic [31:0]      resp_result_q, resp_result_d;
    logic             resp_exc_q, resp_exc_d;

`ifdef MULTDIV_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    logic [LANES-1:0] pick_gnt;
    logic [1:0]       pick_idx;
    logic             pick_any;

    rr_pick4 u_pick (
        .req (req),
        .ptr (ptr_q),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        grant_d       = grant_q;
        mux_sel_d     = mux_sel_q;
        op_d          = op_q;
        mult_d        = 1'b0;
        div_d         = 1'b0;
        resp_valid_d  = '0;
        resp_result_d = resp_result_q;
        resp_exc_d    = resp_exc_q;
`ifdef MULTDIV_ARB_TIMEOUT_EN
        cnt_d         = cnt_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                grant_d = '0;
                if (pick_any) begin
                    grant_d   = pick_gnt;
                    mux_sel_d = pick_idx;
                    op_d      = req_op[pick_idx];
                    // The start pulse is registered here so it is visible
                    // during the ISSUE cycle itself.
                    mult_d    = (req_op[pick_idx] == OP_MULT);
                    div_d     = (req_op[pick_idx] == OP_DIV);
                    state_d   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // Completion is ignored here; the core has only just started.
`ifdef MULTDIV_ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (data_resultRDY) begin
                    resp_result_d = data_result;
                    resp_exc_d    = data_exception;
                    resp_valid_d  = grant_q;
                    state_d       = ST_RESP;
                end
`ifdef MULTDIV_ARB_TIMEOUT_EN
                // A completion on the limit cycle takes the branch above.
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
                    resp_result_d = '0;
                    resp_exc_d    = 1'b1;
                    resp_valid_d  = grant_q;
                    state_d       = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            ST_RESP: begin
                ptr_d   = mux_sel_q + 2'd1;
                grant_d = '0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            ptr_q         <= '0;
            grant_q       <= '0;
            mux_sel_q     <= '0;
            op_q          <= OP_MULT;
            mult_q        <= 1'b0;
            div_q         <= 1'b0;
            resp_valid_q  <= '0;
            resp_result_q <= '0;
            resp_exc_q    <= 1'b0;
`ifdef MULTDIV_ARB_TIMEOUT_EN
            cnt_q         <= '0;
`endif
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            grant_q       <= grant_d;
            mux_sel_q     <= mux_sel_d;
            op_q          <= op_d;
            mult_q        <= mult_d;
            div_q         <= div_d;
            resp_valid_q  <= resp_valid_d;
            resp_result_q <= resp_result_d;
            resp_exc_q    <= resp_exc_d;
`ifdef MULTDIV_ARB_TIMEOUT_EN
            cnt_q         <= cnt_d;
`endif
        end
    end

    assign grant          = grant_q;
    assign mux_sel        = mux_sel_q;
    assign ctrl_MULT      = mult_q;
    assign ctrl_DIV       = div_q;
    assign resp_valid     = resp_valid_q;
    assign resp_result    = resp_result_q;
    assign resp_exception = resp_exc_q;

endmodule
